// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and line idle level.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

   localparam logic UART_IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } uart_tx_state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Modulo-DVSR bit-period counter; tick marks the last clock of each bit period.
// clear restarts the period from zero on the next edge.
module uart_baud_cnt #(
   parameter int DVSR = 868
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int CW = (DVSR > 2) ? $clog2(DVSR) : 1;
   localparam logic [CW-1:0] LAST = CW'(DVSR - 1);

   logic [CW-1:0] s_cnt;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         s_cnt <= '0;
      end else if (s_cnt == LAST) begin
         s_cnt <= '0;
      end else begin
         s_cnt <= s_cnt + CW'(1);
      end
   end

   assign tick = (s_cnt == LAST);

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that pops bytes from an upstream FWFT FIFO and sends them back to back.
// Define UART_TX_PARITY_EN to add a parity bit (even, or odd with PARITY_ODD=1).
//
// state  | meaning
// IDLE   | line high; pop and latch the FIFO head when not empty
// START  | start bit, tx low for one bit period
// DATA   | data bits LSB first from the shift register
// PARITY | parity bit of the latched word (UART_TX_PARITY_EN only)
// STOP   | tx high for STOP_BITS bit periods; done tick on the last clock
module uart_tx_fifo_drain
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DVSR       = 868,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_rd,
   output logic                  tx,
   output logic                  tx_busy,
   output logic                  tx_done_tick
);

   localparam int NW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [NW-1:0] LAST_BIT  = NW'(DATA_WIDTH - 1);
   localparam logic [NW-1:0] LAST_STOP = NW'(STOP_BITS - 1);

   generate
      if (DVSR < 2 || DVSR > 65535 || (STOP_BITS != 1 && STOP_BITS != 2) ||
          (PARITY_ODD != 0 && PARITY_ODD != 1) || DATA_WIDTH < 2) begin : g_bad_param
         $error("uart_tx_fifo_drain: illegal parameter combination");
      end
   endgenerate

   uart_tx_state_t        state_q, state_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic [NW-1:0]         n_cnt_q, n_cnt_d;
   logic                  tx_q, tx_d;
   logic                  baud_clear, baud_tick;
   logic                  pop;

   uart_baud_cnt #(.DVSR(DVSR)) u_baud (
      .clk   (clk),
      .reset (reset),
      .clear (baud_clear),
      .tick  (baud_tick)
   );

   // reset gates the pop so a word is never taken while the FSM is being cleared
   assign pop        = (state_q == IDLE) && !fifo_empty && !reset;
   assign fifo_rd    = pop;
   assign baud_clear = (state_q == IDLE) || (state_d != state_q);

`ifdef UART_TX_PARITY_EN
   logic par_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         par_q <= 1'b0;
      end else if (pop) begin
         par_q <= (^fifo_data) ^ (PARITY_ODD != 0);
      end
   end
`endif

   // tx_d is the line level for the state being entered, so tx stays registered
   always_comb begin
      state_d      = state_q;
      shreg_d      = shreg_q;
      n_cnt_d      = n_cnt_q;
      tx_d         = tx_q;
      tx_done_tick = 1'b0;
      case (state_q)
         IDLE: begin
            tx_d    = UART_IDLE_LEVEL;
            n_cnt_d = '0;
            if (pop) begin
               shreg_d = fifo_data;
               state_d = START;
               tx_d    = 1'b0;
            end
         end
         START: begin
            tx_d = 1'b0;
            if (baud_tick) begin
               state_d = DATA;
               tx_d    = shreg_q[0];
            end
         end
         DATA: begin
            tx_d = shreg_q[0];
            if (baud_tick) begin
               if (n_cnt_q == LAST_BIT) begin
                  n_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
                  tx_d    = par_q;
`else
                  state_d = STOP;
                  tx_d    = UART_IDLE_LEVEL;
`endif
               end else begin
                  n_cnt_d = n_cnt_q + NW'(1);
                  shreg_d = shreg_q >> 1;
                  tx_d    = shreg_d[0];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            tx_d = par_q;
            if (baud_tick) begin
               state_d = STOP;
               tx_d    = UART_IDLE_LEVEL;
            end
         end
`endif
         STOP: begin
            tx_d = UART_IDLE_LEVEL;
            if (baud_tick) begin
               if (n_cnt_q == LAST_STOP) begin
                  n_cnt_d      = '0;
                  state_d      = IDLE;
                  tx_done_tick = 1'b1;
               end else begin
                  n_cnt_d = n_cnt_q + NW'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = UART_IDLE_LEVEL;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         shreg_q <= '0;
         n_cnt_q <= '0;
         tx_q    <= UART_IDLE_LEVEL;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         n_cnt_q <= n_cnt_d;
         tx_q    <= tx_d;
      end
   end

   assign tx      = tx_q;
   assign tx_busy = (state_q != IDLE);

endmodule
